// File: rtl/imem_fetch_unit_if.sv
// Bundle for the fetch stage: redirect from execute, imem request/response, and the decode-side queue head.
// Valid/ready: a transfer happens on a rising edge where valid && ready; a raised valid and its payload stay put until then.
interface imem_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_req_ready;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              inst_valid;
    logic [DATA_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        input  redirect_valid, redirect_pc,
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        output redirect_valid, redirect_pc,
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/imem_fetch_unit.sv
// Stallable fetch stage: one outstanding imem read at a time, results tagged with their PC
// in a 2-entry queue toward decode; a redirect flushes queued and in-flight fetches.
module imem_fetch_unit #(
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
    input  logic               clk,
    input  logic               reset,
    imem_fetch_unit_if.master  bus,
    output logic [1:0]         dbg_state
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    state_t            state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] req_pc;
    logic [1:0]        count;
    logic [DATA_W-1:0] q_data [2];
    logic [ADDR_W-1:0] q_pc   [2];

    logic req_fire;
    logic push;
    logic pop;

    // Requests only go out with a free queue slot, so a response can always be pushed.
    assign bus.imem_req_valid = (state == REQ) && (count < 2'd2) && !bus.redirect_valid;
    assign bus.imem_req_addr  = (state == REQ) ? fetch_pc : '0;
    assign bus.inst_valid     = (count != 2'd0);
    assign bus.inst_data      = q_data[0];
    assign bus.inst_pc        = q_pc[0];
    assign dbg_state          = state;

    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign push     = (state == WAIT) && bus.imem_rsp_valid && !bus.redirect_valid;
    assign pop      = bus.inst_valid && bus.inst_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            fetch_pc <= RESET_VECTOR & ALIGN_MASK;
            req_pc   <= '0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= bus.redirect_pc & ALIGN_MASK;
            // A response still owed to the old stream must be swallowed before refetching.
            case (state)
                WAIT, DROP: state <= bus.imem_rsp_valid ? REQ : DROP;
                default:    state <= REQ;
            endcase
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (req_fire) begin
                        req_pc   <= fetch_pc;
                        fetch_pc <= fetch_pc + ADDR_W'(4);
                        state    <= WAIT;
                    end
                end
                WAIT: if (bus.imem_rsp_valid) state <= REQ;
                DROP: if (bus.imem_rsp_valid) state <= REQ;
                default: state <= IDLE;
            endcase
        end
    end

    // Entry 0 is always the head; a pop shifts entry 1 down.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= 2'd0;
            q_data[0] <= '0;
            q_data[1] <= '0;
            q_pc[0]   <= '0;
            q_pc[1]   <= '0;
        end else if (bus.redirect_valid) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        q_data[0] <= bus.imem_rsp_data;
                        q_pc[0]   <= req_pc;
                    end else begin
                        q_data[1] <= bus.imem_rsp_data;
                        q_pc[1]   <= req_pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    q_data[0] <= q_data[1];
                    q_pc[0]   <= q_pc[1];
                    count     <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        q_data[0] <= bus.imem_rsp_data;
                        q_pc[0]   <= req_pc;
                    end else begin
                        q_data[0] <= q_data[1];
                        q_pc[0]   <= q_pc[1];
                        q_data[1] <= bus.imem_rsp_data;
                        q_pc[1]   <= req_pc;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: streaming, back-pressure, redirects, request hold, PC wrap and async reset.
module tb_imem_fetch_unit;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    logic clk    = 1'b0;
    logic reset  = 1'b0;
    logic reset2 = 1'b0;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state2;
    int checks = 0;
    int errors = 0;

    imem_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    imem_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

    imem_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'h00000000)) dut (
        .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
    );

    imem_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_VECTOR(32'hFFFFFFF8)) dut2 (
        .clk(clk), .reset(reset2), .bus(bus2), .dbg_state(dbg_state2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_state",     32'(dbg_state), 32'(S_IDLE));
        chk("rst_req_valid", 32'(bus.imem_req_valid), 0);
        chk("rst_req_addr",  bus.imem_req_addr, 0);
        chk("rst_inst_valid", 32'(bus.inst_valid), 0);
        chk("rst_inst_data", bus.inst_data, 0);
        chk("rst_inst_pc",   bus.inst_pc, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = '0;
        bus2.imem_req_ready = 1'b0;
        bus2.imem_rsp_valid = 1'b0;
        bus2.imem_rsp_data  = '0;
        bus2.inst_ready     = 1'b0;

        // Streaming: first request in cycle 2, first instruction in cycle 4, then one per two cycles.
        do_reset();
        chk("t1_c1_state", 32'(dbg_state), 32'(S_IDLE));
        chk("t1_c1_req_valid", 32'(bus.imem_req_valid), 0);
        bus.imem_req_ready = 1'b1;
        bus.inst_ready     = 1'b1;
        tick();
        chk("t1_c2_state", 32'(dbg_state), 32'(S_REQ));
        chk("t1_c2_req_valid", 32'(bus.imem_req_valid), 1);
        chk("t1_c2_req_addr", bus.imem_req_addr, 32'h0);
        tick();
        chk("t1_c3_state", 32'(dbg_state), 32'(S_WAIT));
        chk("t1_c3_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t1_c3_inst_valid", 32'(bus.inst_valid), 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000013;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t1_c4_inst_valid", 32'(bus.inst_valid), 1);
        chk("t1_c4_inst_pc", bus.inst_pc, 32'h0);
        chk("t1_c4_inst_data", bus.inst_data, 32'h00000013);
        chk("t1_c4_req_addr", bus.imem_req_addr, 32'h4);
        for (int i = 1; i <= 2; i++) begin
            tick();
            chk("t1_gap_inst_valid", 32'(bus.inst_valid), 0);
            bus.imem_rsp_valid = 1'b1;
            tick();
            bus.imem_rsp_valid = 1'b0;
            #1;
            chk("t1_inst_valid", 32'(bus.inst_valid), 1);
            chk("t1_inst_pc", bus.inst_pc, 32'(4 * i));
            chk("t1_inst_data", bus.inst_data, 32'h00000013);
            chk("t1_req_addr", bus.imem_req_addr, 32'(4 * i + 4));
        end

        // Decode stalled: two entries fill, requests stop, then drain in order and resume at 8.
        do_reset();
        bus.imem_req_ready = 1'b1;
        tick();
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h000000A0;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t2_req_addr4", bus.imem_req_addr, 32'h4);
        chk("t2_head_pc0", bus.inst_pc, 32'h0);
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h000000A4;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t2_full_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t2_full_state", 32'(dbg_state), 32'(S_REQ));
        repeat (5) begin
            tick();
            chk("t2_stall_req_valid", 32'(bus.imem_req_valid), 0);
            chk("t2_stall_head_pc", bus.inst_pc, 32'h0);
        end
        bus.inst_ready = 1'b1;
        #1;
        chk("t2_pop0_data", bus.inst_data, 32'h000000A0);
        tick();
        chk("t2_pop1_pc", bus.inst_pc, 32'h4);
        chk("t2_pop1_data", bus.inst_data, 32'h000000A4);
        chk("t2_resume_valid", 32'(bus.imem_req_valid), 1);
        chk("t2_resume_addr", bus.imem_req_addr, 32'h8);
        tick();
        bus.inst_ready = 1'b0;
        chk("t2_drained", 32'(bus.inst_valid), 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h000000A8;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t2_pc8", bus.inst_pc, 32'h8);
        chk("t2_req_addr12", bus.imem_req_addr, 32'hC);

        // Redirect while WAIT; the late response must be dropped.
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00000103;
        #1;
        chk("t3_redir_state", 32'(dbg_state), 32'(S_WAIT));
        chk("t3_redir_req_valid", 32'(bus.imem_req_valid), 0);
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_drop_state", 32'(dbg_state), 32'(S_DROP));
        chk("t3_flush_inst_valid", 32'(bus.inst_valid), 0);
        chk("t3_drop_req_valid", 32'(bus.imem_req_valid), 0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'hDEADBEEF;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t3_after_state", 32'(dbg_state), 32'(S_REQ));
        chk("t3_no_inst", 32'(bus.inst_valid), 0);
        chk("t3_no_deadbeef", 32'(bus.inst_data === 32'hDEADBEEF), 0);
        chk("t3_target_addr", bus.imem_req_addr, 32'h00000100);
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000011;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t3_target_pc", bus.inst_pc, 32'h00000100);
        chk("t3_target_data", bus.inst_data, 32'h00000011);

        // Redirect colliding with response and pop; then redirect+pop with the queue full.
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000022;
        bus.inst_ready     = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00000200;
        #1;
        chk("t4_coll_req_valid", 32'(bus.imem_req_valid), 0);
        tick();
        bus.imem_rsp_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_coll_inst_valid", 32'(bus.inst_valid), 0);
        chk("t4_coll_state", 32'(dbg_state), 32'(S_REQ));
        chk("t4_coll_addr", bus.imem_req_addr, 32'h00000200);
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000033;
        tick();
        bus.imem_rsp_valid = 1'b0;
        tick();
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000044;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t4_full_req_valid", 32'(bus.imem_req_valid), 0);
        chk("t4_full_head_pc", bus.inst_pc, 32'h00000200);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h00000300;
        bus.inst_ready     = 1'b1;
        tick();
        bus.redirect_valid = 1'b0;
        bus.inst_ready     = 1'b0;
        #1;
        chk("t4_full_flush", 32'(bus.inst_valid), 0);
        chk("t4_full_addr", bus.imem_req_addr, 32'h00000300);

        // Memory back-pressure: request held stable, PC advances only on acceptance.
        bus.imem_req_ready = 1'b0;
        repeat (5) begin
            tick();
            chk("t5_hold_valid", 32'(bus.imem_req_valid), 1);
            chk("t5_hold_addr", bus.imem_req_addr, 32'h00000300);
        end
        bus.imem_req_ready = 1'b1;
        tick();
        chk("t5_accept_state", 32'(dbg_state), 32'(S_WAIT));
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h00000055;
        tick();
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t5_inst_pc", bus.inst_pc, 32'h00000300);
        chk("t5_inst_data", bus.inst_data, 32'h00000055);
        chk("t5_next_addr", bus.imem_req_addr, 32'h00000304);

        // High reset vector: address wrap, then async reset mid-WAIT and a stale response.
        chk("t6_rst_req_valid", 32'(bus2.imem_req_valid), 0);
        chk("t6_rst_req_addr", bus2.imem_req_addr, 0);
        @(negedge clk);
        reset2 = 1'b1;
        bus2.imem_req_ready = 1'b1;
        bus2.inst_ready     = 1'b1;
        tick();
        chk("t6_addr_f8", bus2.imem_req_addr, 32'hFFFFFFF8);
        tick();
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'h00000066;
        tick();
        bus2.imem_rsp_valid = 1'b0;
        #1;
        chk("t6_addr_fc", bus2.imem_req_addr, 32'hFFFFFFFC);
        chk("t6_pc_f8", bus2.inst_pc, 32'hFFFFFFF8);
        tick();
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'h00000077;
        tick();
        bus2.imem_rsp_valid = 1'b0;
        #1;
        chk("t6_addr_wrap", bus2.imem_req_addr, 32'h00000000);
        chk("t6_wrap_valid", 32'(bus2.imem_req_valid), 1);
        chk("t6_pc_fc", bus2.inst_pc, 32'hFFFFFFFC);
        tick();
        chk("t6_wait", 32'(dbg_state2), 32'(S_WAIT));
        reset2 = 1'b0;
        #1;
        chk("t6_async_state", 32'(dbg_state2), 32'(S_IDLE));
        chk("t6_async_req_valid", 32'(bus2.imem_req_valid), 0);
        chk("t6_async_inst_valid", 32'(bus2.inst_valid), 0);
        chk("t6_async_inst_pc", bus2.inst_pc, 0);
        chk("t6_async_inst_data", bus2.inst_data, 0);
        @(negedge clk);
        reset2 = 1'b1;
        bus2.imem_rsp_valid = 1'b1;
        bus2.imem_rsp_data  = 32'h00000099;
        tick();
        bus2.imem_rsp_valid = 1'b0;
        #1;
        chk("t6_stale_ignored", 32'(bus2.inst_valid), 0);
        chk("t6_restart_addr", bus2.imem_req_addr, 32'hFFFFFFF8);
        chk("t6_restart_valid", 32'(bus2.imem_req_valid), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
